// File: rtl/lut_cfg_pkg.sv
// Shared types and sizing helpers for the LUT configuration loader.
// A load is one bitstream of TOTAL_WORDS words shifted serially into a LUT chain.
package lut_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } load_state_e;

    // Number of shift cycles needed to fill one LUT's truth table.
    function automatic int loading_cycles(input int ninputs, input int width);
        return (1 << ninputs) / width;
    endfunction

    function automatic int total_words(input int nluts, input int cycles_per_lut);
        return nluts * cycles_per_lut;
    endfunction

endpackage

// File: rtl/lut_config_loader.sv
// Streams bitstream words into a daisy-chained set of LUTs, one shift per accepted word,
// with stall timeout, abort and a one-cycle done pulse after the final shift.
module lut_config_loader
    import lut_cfg_pkg::*;
#(
    parameter int LUT_NINPUTS  = 4,
    parameter int CONFIG_WIDTH = 1,
    parameter int NUM_LUTS     = 1,
    parameter int STALL_LIMIT  = 1000
) (
    input  logic                    config_clk,
    input  logic                    config_rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    in_valid,
    input  logic [CONFIG_WIDTH-1:0] in_data,
    output logic                    in_ready,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic [NUM_LUTS-1:0]     config_en,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam int LOADING_CYCLES = loading_cycles(LUT_NINPUTS, CONFIG_WIDTH);
    localparam int TOTAL_WORDS    = total_words(NUM_LUTS, LOADING_CYCLES);
    localparam int WORD_W         = $clog2(TOTAL_WORDS + 1);
    localparam int STALL_W        = $clog2(STALL_LIMIT + 1);

    localparam logic [WORD_W-1:0]  LAST_WORD  = WORD_W'(TOTAL_WORDS - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);

    load_state_e              state, state_nxt;
    logic [WORD_W-1:0]        word_cnt, word_cnt_nxt;
    logic [STALL_W-1:0]       stall_cnt, stall_cnt_nxt;
    logic [CONFIG_WIDTH-1:0]  out_q, out_nxt;
    logic                     en_q, en_nxt;
    logic                     done_q, done_nxt;
    logic                     err_q, err_nxt;

    always_ff @(posedge config_clk) begin
        if (!config_rst_n) begin
            state     <= ST_IDLE;
            word_cnt  <= '0;
            stall_cnt <= '0;
            out_q     <= '0;
            en_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            word_cnt  <= word_cnt_nxt;
            stall_cnt <= stall_cnt_nxt;
            out_q     <= out_nxt;
            en_q      <= en_nxt;
            done_q    <= done_nxt;
            err_q     <= err_nxt;
        end
    end

    // Abort wins over an offered word, so a word presented alongside abort is never shifted.
    always_comb begin
        state_nxt     = state;
        word_cnt_nxt  = word_cnt;
        stall_cnt_nxt = stall_cnt;
        out_nxt       = out_q;
        en_nxt        = 1'b0;
        done_nxt      = 1'b0;
        err_nxt       = err_q;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt     = ST_LOAD;
                    word_cnt_nxt  = '0;
                    stall_cnt_nxt = '0;
                    err_nxt       = 1'b0;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (in_valid) begin
                    en_nxt        = 1'b1;
                    out_nxt       = in_data;
                    stall_cnt_nxt = '0;
                    word_cnt_nxt  = word_cnt + WORD_W'(1);
                    if (word_cnt == LAST_WORD) begin
                        state_nxt = ST_FLUSH;
                    end
                end else begin
                    stall_cnt_nxt = stall_cnt + STALL_W'(1);
                    if (stall_cnt == STALL_LAST) begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                state_nxt = ST_IDLE;
                done_nxt  = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign in_ready   = (state == ST_LOAD) && !abort;
    assign busy       = (state != ST_IDLE);
    assign config_out = out_q;
    assign config_en  = {NUM_LUTS{en_q}};
    assign done       = done_q;
    assign error      = err_q;

endmodule

// File: tb/tb_lut_config_loader.sv
// Bench for lut_config_loader: single-LUT and two-LUT chains modelled as shift registers,
// checked cycle by cycle against a behavioural loader model plus final truth-table contents.
module tb_lut_config_loader;

    localparam int LIMIT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, abort, in_valid, sel;
    logic [0:0] in_data;

    logic       ready_a, busy_a, done_a, err_a;
    logic [0:0] out_a, en_a;
    logic       ready_b, busy_b, done_b, err_b;
    logic [0:0] out_b;
    logic [1:0] en_b;

    lut_config_loader #(.LUT_NINPUTS(4), .CONFIG_WIDTH(1), .NUM_LUTS(1), .STALL_LIMIT(LIMIT)) dut_a (
        .config_clk(clk), .config_rst_n(rst_n), .start(start && !sel), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ready_a), .config_out(out_a),
        .config_en(en_a), .busy(busy_a), .done(done_a), .error(err_a)
    );

    lut_config_loader #(.LUT_NINPUTS(4), .CONFIG_WIDTH(1), .NUM_LUTS(2), .STALL_LIMIT(LIMIT)) dut_b (
        .config_clk(clk), .config_rst_n(rst_n), .start(start && sel), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ready_b), .config_out(out_b),
        .config_en(en_b), .busy(busy_b), .done(done_b), .error(err_b)
    );

    logic        obs_ready, obs_busy, obs_done, obs_err, obs_out;
    logic [31:0] obs_en32;
    assign obs_ready = sel ? ready_b : ready_a;
    assign obs_busy  = sel ? busy_b  : busy_a;
    assign obs_done  = sel ? done_b  : done_a;
    assign obs_err   = sel ? err_b   : err_a;
    assign obs_out   = sel ? out_b[0] : out_a[0];
    assign obs_en32  = sel ? {30'd0, en_b} : {31'd0, en_a};

    // LUT truth tables: head is address 15, each shift moves toward address 0 and on down the chain.
    logic [15:0] lut_a, lut_b0, lut_b1;
    always @(posedge clk) begin
        if (en_a[0]) lut_a  <= {out_a[0], lut_a[15:1]};
        if (en_b[0]) lut_b0 <= {out_b[0], lut_b0[15:1]};
        if (en_b[1]) lut_b1 <= {lut_b0[0], lut_b1[15:1]};
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt, done_cyc, en_cnt, acc_cyc;
    bit chk_on = 1'b0;
    logic words [0:31];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a load is "active" until all words arrive, a stall expires or abort hits.
    bit   m_loading, m_flushing, m_done, m_err, m_en, m_out;
    int   m_count, m_stall;
    always @(posedge clk) begin
        automatic int w = sel ? 32 : 16;
        if (!rst_n) begin
            m_loading = 0; m_flushing = 0; m_count = 0; m_stall = 0;
            m_err = 0; m_done = 0; m_en = 0; m_out = 0;
        end else begin
            m_done = 0;
            m_en   = 0;
            if (m_flushing) begin
                m_flushing = 0;
                m_done = 1;
            end else if (m_loading) begin
                if (abort) begin
                    m_loading = 0;
                end else if (in_valid) begin
                    m_en = 1; m_out = in_data[0]; m_stall = 0; m_count++;
                    if (m_count == w) begin m_loading = 0; m_flushing = 1; end
                end else begin
                    m_stall++;
                    if (m_stall == LIMIT) begin m_err = 1; m_loading = 0; end
                end
            end else if (start) begin
                m_loading = 1; m_count = 0; m_stall = 0; m_err = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (obs_done) begin done_cnt++; done_cyc = cyc; end
        if (obs_en32 != 0) en_cnt++;
        if (chk_on) begin
            check_output("in_ready", obs_ready, m_loading && !abort);
            check_output("busy", obs_busy, m_loading || m_flushing);
            check_output("done", obs_done, m_done);
            check_output("error", obs_err, m_err);
            check_output("config_en", obs_en32, m_en ? (sel ? 32'd3 : 32'd1) : 32'd0);
            check_output("config_out", obs_out, m_out);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic start, abort, valid, data;
        logic exp_ready, exp_en, exp_busy, exp_out;
    } vec_t;

    task automatic apply_stimulus(input vec_t v, input int idx);
        start = v.start; abort = v.abort; in_valid = v.valid; in_data = v.data;
        #1;
        check_output($sformatf("vec%0d_ready", idx), obs_ready, v.exp_ready);
        step();
        check_output($sformatf("vec%0d_en", idx), obs_en32, v.exp_en ? 32'd1 : 32'd0);
        check_output($sformatf("vec%0d_busy", idx), obs_busy, v.exp_busy);
        check_output($sformatf("vec%0d_out", idx), obs_out, v.exp_out);
        check_output($sformatf("vec%0d_done", idx), obs_done, 1'b0);
    endtask

    task automatic run_load(input int n, input int max_gap, input bit flush_abort);
        start = 1; step(); start = 0;
        for (int i = 0; i < n; i++) begin
            automatic int gaps = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
            repeat (gaps) begin in_valid = 0; step(); end
            in_valid = 1; in_data = words[i];
            step();
            if (i == 0) acc_cyc = cyc;
        end
        in_valid = flush_abort; abort = flush_abort;
        step();
        in_valid = 0; abort = 0;
        step(); step();
    endtask

    // First accepted word lands at the chain tail, the last at the head of LUT 0.
    task automatic check_lut(input int n);
        logic [15:0] e0, e1;
        e0 = '0; e1 = '0;
        for (int j = 0; j < n; j++) begin
            automatic int d = n - 1 - j;
            if (d / 16 == 0) e0[15 - d % 16] = words[j];
            else             e1[15 - d % 16] = words[j];
        end
        if (n == 16) begin
            check_output("lut_readback", {16'd0, lut_a}, {16'd0, e0});
        end else begin
            check_output("lut0_readback", {16'd0, lut_b0}, {16'd0, e0});
            check_output("lut1_readback", {16'd0, lut_b1}, {16'd0, e1});
        end
    endtask

    task automatic set_pattern(input logic [15:0] p);
        for (int i = 0; i < 16; i++) words[i] = p[i];
    endtask

    initial begin
        vec_t vecs [7];
        vecs[0] = '{0, 1, 1, 1,  0, 0, 0, 0};
        vecs[1] = '{1, 1, 1, 1,  0, 0, 1, 0};
        vecs[2] = '{0, 0, 1, 1,  1, 1, 1, 1};
        vecs[3] = '{1, 0, 0, 0,  1, 0, 1, 1};
        vecs[4] = '{0, 1, 1, 0,  0, 0, 0, 1};
        vecs[5] = '{0, 1, 0, 0,  0, 0, 0, 1};
        vecs[6] = '{0, 0, 1, 0,  0, 0, 0, 1};

        sel = 0; rst_n = 0; start = 0; abort = 0; in_valid = 0; in_data = 0;
        done_cnt = 0; en_cnt = 0;
        step(); step();
        chk_on = 1;
        check_output("rst_busy", obs_busy, 0);
        check_output("rst_en", obs_en32, 0);
        check_output("rst_out", obs_out, 0);
        check_output("rst_error", obs_err, 0);
        rst_n = 1;
        step();

        for (int i = 0; i < 7; i++) apply_stimulus(vecs[i], i);
        start = 0; abort = 0; in_valid = 0;
        step();

        $display("[TB] back-to-back load 0xA5A5");
        set_pattern(16'hA5A5); done_cnt = 0; en_cnt = 0;
        run_load(16, 0, 0);
        check_lut(16);
        check_output("b2b_done_count", done_cnt, 1);
        check_output("b2b_en_cycles", en_cnt, 16);
        check_output("b2b_done_latency", done_cyc + 1 - acc_cyc, 17);

        $display("[TB] gapped random load, abort during flush");
        for (int i = 0; i < 16; i++) words[i] = 1'($urandom);
        done_cnt = 0; en_cnt = 0;
        run_load(16, 3, 1);
        check_lut(16);
        check_output("gap_done_count", done_cnt, 1);
        check_output("gap_en_cycles", en_cnt, 16);

        $display("[TB] stall timeout");
        set_pattern(16'hFFFF); done_cnt = 0;
        start = 1; step(); start = 0;
        for (int i = 0; i < 5; i++) begin in_valid = 1; in_data = 1; step(); end
        in_valid = 0;
        repeat (LIMIT - 1) step();
        check_output("stall_busy_before", obs_busy, 1);
        check_output("stall_err_before", obs_err, 0);
        step();
        check_output("stall_busy", obs_busy, 0);
        check_output("stall_err", obs_err, 1);
        step(); step();
        check_output("stall_err_sticky", obs_err, 1);
        check_output("stall_no_done", done_cnt, 0);

        $display("[TB] abort with word 10 offered");
        for (int i = 0; i < 16; i++) words[i] = 1'($urandom);
        words[9] = 1; words[10] = 0;
        done_cnt = 0;
        start = 1; step(); start = 0;
        check_output("abort_err_cleared", obs_err, 0);
        for (int i = 0; i < 10; i++) begin in_valid = 1; in_data = words[i]; step(); end
        abort = 1; in_valid = 1; in_data = words[10];
        #1;
        check_output("abort_ready_masked", obs_ready, 0);
        step();
        abort = 0; in_valid = 0;
        check_output("abort_busy", obs_busy, 0);
        check_output("abort_en", obs_en32, 0);
        check_output("abort_out_held", obs_out, 1);
        step(); step();
        check_output("abort_no_done", done_cnt, 0);
        set_pattern(16'h0F0F); done_cnt = 0;
        run_load(16, 0, 0);
        check_lut(16);
        check_output("reload_done_count", done_cnt, 1);

        $display("[TB] reset mid-load");
        for (int i = 0; i < 16; i++) words[i] = 1'($urandom);
        words[6] = 1;
        start = 1; step(); start = 0;
        for (int i = 0; i < 7; i++) begin in_valid = 1; in_data = words[i]; step(); end
        rst_n = 0; start = 1; in_valid = 1;
        step();
        check_output("midrst_busy", obs_busy, 0);
        check_output("midrst_out", obs_out, 0);
        check_output("midrst_en", obs_en32, 0);
        step();
        rst_n = 1; start = 0; in_valid = 0;
        step();
        check_output("midrst_start_ignored", obs_busy, 0);
        for (int i = 0; i < 16; i++) words[i] = 1'($urandom);
        done_cnt = 0;
        run_load(16, 1, 0);
        check_lut(16);
        check_output("midrst_done_count", done_cnt, 1);

        $display("[TB] random session");
        for (int c = 0; c < 400; c++) begin
            start    = ($urandom_range(9, 0) == 0);
            abort    = ($urandom_range(19, 0) == 0);
            in_valid = ($urandom_range(9, 0) < 7);
            in_data  = 1'($urandom);
            step();
        end
        start = 0; abort = 0; in_valid = 0;

        $display("[TB] two-LUT chain");
        rst_n = 0; step();
        sel = 1; step();
        rst_n = 1; step();
        for (int i = 0; i < 32; i++) words[i] = 1'($urandom);
        done_cnt = 0; en_cnt = 0;
        run_load(32, 2, 0);
        check_lut(32);
        check_output("chain_done_count", done_cnt, 1);
        check_output("chain_en_cycles", en_cnt, 32);

        chk_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/lut_config_loader.md
LUT_CONFIG_LOADER -- requirements
Module: lut_config_loader

Interface
REQ-001 Parameters SHALL be: LUT_NINPUTS, default 4, LUT address width; CONFIG_WIDTH, default 1, config word width; NUM_LUTS, default 1, LUTs on the chain; STALL_LIMIT, default 1000, maximum idle cycles in LOAD.
REQ-002 Derived constants SHALL be: LOADING_CYCLES = 2**LUT_NINPUTS / CONFIG_WIDTH; TOTAL_WORDS = NUM_LUTS*LOADING_CYCLES.
REQ-003 Ports SHALL be:
- config_clk  in  1  sole clock; all state updates on rising edge.
- config_rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle load request.
- abort  in  1  cancel the load in progress.
- in_valid  in  1  in_data holds a valid word.
- in_data  in  CONFIG_WIDTH  bitstream word.
- in_ready  out  1  loader accepts a word this cycle.
- config_out  out  CONFIG_WIDTH  drives config_in of chain head LUT.
- config_en  out  NUM_LUTS  per-LUT shift enable.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse on successful load.
- error  out  1  sticky stall-timeout flag.

Function
REQ-004 FSM SHALL have states IDLE, LOAD, FLUSH.
REQ-005 IDLE: start=1 SHALL move to LOAD next edge, clear word counter, stall counter and error; start in any other state SHALL be ignored.
REQ-006 in_ready SHALL be 1 only in LOAD; a word is accepted on an edge where in_valid && in_ready.
REQ-007 Each accepted word SHALL be registered into config_out, with config_en = all ones, for exactly the following cycle, so the chain shifts once per accepted word.
REQ-008 In any cycle following a non-accept edge, config_en SHALL be all zeros and config_out SHALL hold its last value.
REQ-009 All config_en bits SHALL always be equal.
REQ-010 Word counter SHALL count accepted words, 0..TOTAL_WORDS-1; acceptance of word TOTAL_WORDS-1 SHALL move to FLUSH.
REQ-011 FLUSH SHALL last one cycle, during which the final shift occurs; then IDLE with done=1 for that single cycle.
REQ-012 Bit order: first accepted word SHALL end in the tail position of the last LUT; the last accepted word SHALL end in the head position of LUT 0.
REQ-013 busy SHALL be 1 in LOAD and FLUSH, else 0.
REQ-014 Stall counter SHALL increment each LOAD cycle with no accept and clear on accept; on reaching STALL_LIMIT, error SHALL be set, FSM SHALL go to IDLE, and done SHALL NOT pulse.
REQ-015 abort=1 in LOAD SHALL force IDLE next edge with config_en zero from that edge, no done, error unchanged; a word offered in that cycle SHALL NOT be accepted (abort masks in_ready).
REQ-016 abort in FLUSH SHALL be ignored; abort in IDLE SHALL have no effect.
REQ-017 Simultaneous start and abort in IDLE SHALL start the load (abort ignored).
REQ-018 Words offered in IDLE or FLUSH SHALL be ignored and not counted.

Reset
REQ-019 config_rst_n=0 at an edge SHALL force IDLE, counters 0, config_out 0, config_en 0, in_ready 0, busy 0, done 0, error 0, including mid-load; the chain contents are then undefined and a full reload is required.

Structure
REQ-020 Package lut_cfg_pkg SHALL hold the FSM state typedef and the LOADING_CYCLES/TOTAL_WORDS computation functions.
REQ-021 Word and stall counters SHALL be inline; no sub-module. Counter widths SHALL be $clog2(TOTAL_WORDS+1) and $clog2(STALL_LIMIT+1).

Verification
REQ-022 Bench SHALL use the default parameters (16 words) driving one lut instance, and SHALL cover:
- Back-to-back load: start, 16 words 0xA5A5 LSB-first, valid held high -> 16 config_en cycles; done 17 cycles after first accept; all LUT addresses 0..15 read back pattern.
- Gapped load: in_valid toggled 1/0 -> config_en high only after accepts; same final contents; done once.
- Stall: STALL_LIMIT=8, stop after 5 words -> error=1 and busy=0 after 8 idle cycles; done never pulses.
- Abort: abort asserted with word 10 offered -> word not accepted, IDLE next edge, done=0; reload 0x0F0F -> correct readback.
- Reset mid-load: config_rst_n low after word 7 -> all outputs 0 next edge; start ignored during reset; full load then passes.
- Two-LUT chain: NUM_LUTS=2, 32 words -> LUT1 holds first 16 words, LUT0 holds last 16.
